// File: rtl/alu_stage.sv
// Execute-stage ALU: selects operand B, computes the coded operation and registers
// the result together with zero and signed-overflow flags (one-cycle latency).
module alu_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] RF_A,
  input  logic [WIDTH-1:0] RF_B,
  input  logic [WIDTH-1:0] Immed,
  input  logic [3:0]       ALU_func,
  input  logic             ALU_Bin_sel,
  output logic [WIDTH-1:0] ALU_out,
  output logic             Zero,
  output logic             Ovf
);

  localparam int unsigned Msb = WIDTH - 1;

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpAnd  = 4'b0010;
  localparam logic [3:0] OpOr   = 4'b0011;
  localparam logic [3:0] OpNot  = 4'b0100;
  localparam logic [3:0] OpSra  = 4'b1000;
  localparam logic [3:0] OpSrl  = 4'b1001;
  localparam logic [3:0] OpSll  = 4'b1010;
  localparam logic [3:0] OpRol  = 4'b1100;
  localparam logic [3:0] OpRor  = 4'b1101;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] result_d;
  logic             ovf_d;
  logic             zero_d;

  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ovf_q;

  assign op_a = RF_A;
  assign op_b = ALU_Bin_sel ? Immed : RF_B;
  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  always_comb begin
    result_d = '0;
    ovf_d    = 1'b0;
    unique case (ALU_func)
      OpAdd: begin
        result_d = sum;
        ovf_d    = (op_a[Msb] == op_b[Msb]) && (sum[Msb] != op_a[Msb]);
      end
      OpSub: begin
        result_d = diff;
        ovf_d    = (op_a[Msb] != op_b[Msb]) && (diff[Msb] != op_a[Msb]);
      end
      OpAnd:   result_d = op_a & op_b;
      OpOr:    result_d = op_a | op_b;
      OpNot:   result_d = ~op_a;
      OpSra:   result_d = {op_a[Msb], op_a[Msb:1]};
      OpSrl:   result_d = {1'b0, op_a[Msb:1]};
      OpSll:   result_d = {op_a[Msb-1:0], 1'b0};
      OpRol:   result_d = {op_a[Msb-1:0], op_a[Msb]};
      OpRor:   result_d = {op_a[0], op_a[Msb:1]};
      default: begin
        result_d = '0;
        ovf_d    = 1'b0;
      end
    endcase
  end

  assign zero_d = (result_d == '0);

  // Reset state reports a zero result, so Zero comes up set.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ALU_out = result_q;
  assign Zero    = zero_q;
  assign Ovf     = ovf_q;

endmodule

// File: tb/tb_alu_stage.sv
// Directed bench for alu_stage; expected results are queued when stimulus is driven
// and checked one clock later when the registered outputs are valid.
module tb_alu_stage;

  localparam int unsigned WIDTH = 32;

  logic             Clk;
  logic             Reset;
  logic [WIDTH-1:0] RF_A;
  logic [WIDTH-1:0] RF_B;
  logic [WIDTH-1:0] Immed;
  logic [3:0]       ALU_func;
  logic             ALU_Bin_sel;
  logic [WIDTH-1:0] ALU_out;
  logic             Zero;
  logic             Ovf;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   clk_en   = 1'b0;

  alu_stage #(.WIDTH(WIDTH)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .RF_A       (RF_A),
    .RF_B       (RF_B),
    .Immed      (Immed),
    .ALU_func   (ALU_func),
    .ALU_Bin_sel(ALU_Bin_sel),
    .ALU_out    (ALU_out),
    .Zero       (Zero),
    .Ovf        (Ovf)
  );

  initial begin
    Clk = 1'b0;
    forever begin
      #5;
      if (clk_en) Clk = ~Clk;
    end
  end

  task automatic check_val(input string tag, input logic [WIDTH-1:0] obs,
                           input logic [WIDTH-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [WIDTH-1:0] e_out,
                               input logic e_zero, input logic e_ovf);
    check_val({tag, ".out"}, ALU_out, e_out);
    check_val({tag, ".zero"}, {31'b0, Zero}, {31'b0, e_zero});
    check_val({tag, ".ovf"}, {31'b0, Ovf}, {31'b0, e_ovf});
  endtask

  // Drive one operation, clock it through, and compare against the queued expectation.
  task automatic step(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] imm, input logic [3:0] func, input logic sel,
                      input logic [WIDTH-1:0] e_out, input logic e_zero, input logic e_ovf);
    exp_t e;
    RF_A        = a;
    RF_B        = b;
    Immed       = imm;
    ALU_func    = func;
    ALU_Bin_sel = sel;
    e.tag  = tag;
    e.out  = e_out;
    e.zero = e_zero;
    e.ovf  = e_ovf;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check_outputs(e.tag, e.out, e.zero, e.ovf);
    end
    @(negedge Clk);
  endtask

  initial begin
    RF_A        = 32'hDEAD_BEEF;
    RF_B        = 32'h1234_5678;
    Immed       = 32'hFFFF_FFFF;
    ALU_func    = 4'b0000;
    ALU_Bin_sel = 1'b0;
    Reset       = 1'b1;
    #3;
    // Asynchronous reset with the clock stopped.
    Reset = 1'b0;
    #2;
    check_outputs("reset_noclk", 32'h0, 1'b1, 1'b0);

    clk_en = 1'b1;
    @(negedge Clk);
    check_outputs("reset_held", 32'h0, 1'b1, 1'b0);
    Reset = 1'b1;

    step("add_first",  32'h1, 32'h4, 32'h0, 4'b0000, 1'b0, 32'h0000_0005, 1'b0, 1'b0);
    step("add_imm",    32'h1, 32'h4, 32'hC, 4'b0000, 1'b1, 32'h0000_000D, 1'b0, 1'b0);
    step("or_imm",     32'h1, 32'h4, 32'hC, 4'b0011, 1'b1, 32'h0000_000D, 1'b0, 1'b0);
    step("not_a",      32'h1, 32'h4, 32'hC, 4'b0100, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    step("ror",        32'h1, 32'h7, 32'h3, 4'b1101, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
    step("rol",        32'h8000_0001, 32'h5, 32'h9, 4'b1100, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
    step("sra",        32'h8000_0001, 32'h5, 32'h9, 4'b1000, 1'b1, 32'hC000_0000, 1'b0, 1'b0);
    step("srl",        32'h8000_0001, 32'h5, 32'h9, 4'b1001, 1'b0, 32'h4000_0000, 1'b0, 1'b0);
    step("sll",        32'h8000_0001, 32'h5, 32'h9, 4'b1010, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
    step("add_ovf",    32'h7FFF_FFFF, 32'h1, 32'h0, 4'b0000, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    step("sub_ovf",    32'h8000_0000, 32'h1, 32'h0, 4'b0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    step("sub_ovf2",   32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 4'b0001, 1'b0,
         32'h8000_0000, 1'b0, 1'b1);
    step("sub_zero",   32'h5, 32'h5, 32'h0, 4'b0001, 1'b0, 32'h0, 1'b1, 1'b0);
    step("add_wrap",   32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0000, 1'b0, 32'h0, 1'b1, 1'b0);
    step("sub_neg",    32'h0, 32'h1, 32'h0, 4'b0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step("undef_0111", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0111, 1'b0,
         32'h0, 1'b1, 1'b0);
    step("undef_1111", 32'h1, 32'h1, 32'h1, 4'b1111, 1'b0, 32'h0, 1'b1, 1'b0);
    step("and_rfb",    32'hF0F0_F0F0, 32'h0000_FFFF, 32'hFFFF_0000, 4'b0010, 1'b0,
         32'h0000_F0F0, 1'b0, 1'b0);
    step("and_imm",    32'hF0F0_F0F0, 32'h0000_FFFF, 32'hFFFF_0000, 4'b0010, 1'b1,
         32'hF0F0_0000, 1'b0, 1'b0);
    step("and_none",   32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_0000, 4'b0010, 1'b0,
         32'h0, 1'b1, 1'b0);

    // Load 0xD, then assert reset between edges while the clock is high.
    RF_A = 32'h1; Immed = 32'hC; ALU_func = 4'b0000; ALU_Bin_sel = 1'b1;
    @(posedge Clk);
    #1;
    check_outputs("pre_midreset", 32'h0000_000D, 1'b0, 1'b0);
    #2;
    Reset = 1'b0;
    #1;
    check_outputs("midreset", 32'h0, 1'b1, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    step("post_reset", 32'h2, 32'h3, 32'h0, 4'b0000, 1'b0, 32'h0000_0005, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
